// File: rtl/add_round_key_stage_pkg.sv
// Shared AES definitions: state and round-tag types, round counts per key size,
// and the entry record carried by the AddRoundKey output stage.
package AESDefinitions;

  localparam int AES_STATE_SIZE = 16;

  localparam int unsigned AES128_ROUNDS = 10;
  localparam int unsigned AES192_ROUNDS = 12;
  localparam int unsigned AES256_ROUNDS = 14;

  typedef logic [AES_STATE_SIZE-1:0][7:0] state_t;
  typedef logic [3:0]                     roundIdx_t;

  // One buffered result: keyed state plus its round tag and final-round flag.
  typedef struct packed {
    state_t    state;
    roundIdx_t round;
    logic      last;
  } ark_entry_t;

  // Full-width compare, so tags above the final round never alias to it.
  function automatic logic is_final_round(input roundIdx_t r, input int unsigned num_rounds);
    return (32'(r) == num_rounds);
  endfunction

endpackage

// File: rtl/add_round_key_stage_add_round_key.sv
// AddRoundKey: purely combinational bytewise XOR of state and round key.
// Shared with the iterative core, so it carries no storage of its own.
module AddRoundKey
  import AESDefinitions::*;
(
  input  state_t state_i,
  input  state_t key_i,
  output state_t state_o
);

  // XOR every byte of the state with the matching key byte.
  always_comb begin
    state_o = '0;
    for (int i = 0; i < AES_STATE_SIZE; i++) begin
      state_o[i] = state_i[i] ^ key_i[i];
    end
  end

endmodule

// File: rtl/add_round_key_stage.sv
// add_round_key_stage: registered AddRoundKey stage with a valid/ready output.
// Optional build macro ADD_ROUND_KEY_SKID_EN adds a skid register so inReady
// comes straight from a flop; otherwise a single output register is used and
// inReady is combinational from outReady. DEBUG enables a transfer trace.
//
// Handshake: a transfer happens at a rising clock edge when valid and ready
// are both high; a producer holds valid and its data until that edge, and the
// stage holds outState/outRound/outLast stable while outValid && !outReady.
module add_round_key_stage
  import AESDefinitions::*;
#(
  parameter int unsigned NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      inValid,
  output logic      inReady,
  input  state_t    inState,
  input  state_t    inKey,
  input  roundIdx_t inRound,
  output logic      outValid,
  input  logic      outReady,
  output state_t    outState,
  output roundIdx_t outRound,
  output logic      outLast
);

  state_t     xor_state;
  ark_entry_t in_entry;
  ark_entry_t out_q, out_d;
  logic       out_valid_q, out_valid_d;
  logic       accept;
  logic       emit;

  AddRoundKey u_add_round_key (
    .state_i (inState),
    .key_i   (inKey),
    .state_o (xor_state)
  );

  // Build the entry ahead of the register: XOR and last flag are both registered.
  always_comb begin
    in_entry.state = xor_state;
    in_entry.round = inRound;
    in_entry.last  = is_final_round(inRound, NUM_ROUNDS);
  end

  assign accept = inValid && inReady;
  assign emit   = out_valid_q && outReady;

`ifdef ADD_ROUND_KEY_SKID_EN
  ark_entry_t skid_q, skid_d;
  logic       skid_valid_q, skid_valid_d;

  assign inReady = !skid_valid_q;

  // Two-entry occupancy: skid fills only when the output register is stalled,
  // and empties into the output register on the next emit.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (emit) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d = in_entry;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (out_valid_q) begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end else begin
        out_d       = in_entry;
        out_valid_d = 1'b1;
      end
    end
  end

  // Skid register; reset discards its contents immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign inReady = !out_valid_q || outReady;

  // Single output register: load on accept, clear valid on a bare emit.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_d       = in_entry;
      out_valid_d = 1'b1;
    end else if (emit) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  // Output register; reset drops outValid and clears the data asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign outValid = out_valid_q;
  assign outState = out_q.state;
  assign outRound = out_q.round;
  assign outLast  = out_q.last;

`ifdef DEBUG
  // Trace accepted inputs and emitted outputs.
  always @(posedge clock) begin
    if (!reset && accept) $display("ark in : round=%0d state=%h key=%h", inRound, inState, inKey);
    if (!reset && emit)   $display("ark out: round=%0d last=%0d state=%h", outRound, outLast, outState);
  end
`endif

endmodule
